// File: rtl/dot_product_stream_if.sv
// Operand-beat and result handshake bundle for dot_product_stream.
// The engine uses the slave view; the operand source / result sink uses master.
interface dot_product_stream_if #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16
);
    localparam int PW = 2 * DW;
    localparam int LW = PW + $clog2(N);
    localparam int OW = LW + $clog2(MAX_BEATS);
    localparam int BW = $clog2(MAX_BEATS) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [N*DW-1:0]   inp1;
    logic [N*DW-1:0]   inp2;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     sums;
    logic [BW-1:0]     out_beats;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_last, inp1, inp2, out_ready,
        output in_ready, out_valid, sums, out_beats, out_ovf
    );

    modport master (
        output in_valid, in_last, inp1, inp2, out_ready,
        input  in_ready, out_valid, sums, out_beats, out_ovf
    );
endinterface

// File: rtl/dot_product_stream.sv
// Streaming N-lane dot product accumulated over up to MAX_BEATS beats per vector.
// Latency: last beat accepted on edge E0 -> result valid after edge E2.
// Backpressure: a held result (out_valid && !out_ready) freezes the whole pipe; in_ready = !that.
module dot_product_stream #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16,
    parameter int SIGNED    = 1
) (
    input logic                 clk,
    input logic                 reset,
    dot_product_stream_if.slave bus
);
    localparam int PW = 2 * DW;
    localparam int LW = PW + $clog2(N);
    localparam int OW = LW + $clog2(MAX_BEATS);
    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam logic [BW-1:0] MAXB = BW'(MAX_BEATS);

    logic          w_adv;
    logic [PW-1:0] w_prod [N];
    logic [LW-1:0] w_pext;
    logic [LW-1:0] w_lsum;
    logic [OW-1:0] w_s2_ext;
    logic [OW-1:0] w_acc_sum;
    logic [BW-1:0] w_cnt_inc;
    logic          w_ovf_next;

    logic          r_s1_vld;
    logic          r_s1_last;
    logic [PW-1:0] r_prod [N];
    logic          r_s2_vld;
    logic          r_s2_last;
    logic [LW-1:0] r_s2_sum;
    logic [OW-1:0] r_acc;
    logic [BW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_out_vld;
    logic [OW-1:0] r_sums;
    logic [BW-1:0] r_beats;
    logic          r_out_ovf;

    assign w_adv        = !(r_out_vld && !bus.out_ready);
    assign bus.in_ready = w_adv;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (SIGNED != 0)
                w_prod[i] = PW'($signed(bus.inp1[i*DW +: DW])) * PW'($signed(bus.inp2[i*DW +: DW]));
            else
                w_prod[i] = PW'(bus.inp1[i*DW +: DW]) * PW'(bus.inp2[i*DW +: DW]);
        end
    end

    always_comb begin
        w_pext = '0;
        w_lsum = '0;
        for (int i = 0; i < N; i++) begin
            if (SIGNED != 0)
                w_pext = LW'($signed(r_prod[i]));
            else
                w_pext = LW'(r_prod[i]);
            w_lsum = w_lsum + w_pext;
        end
    end

    always_comb begin
        if (SIGNED != 0)
            w_s2_ext = OW'($signed(r_s2_sum));
        else
            w_s2_ext = OW'(r_s2_sum);
        w_acc_sum  = r_acc + w_s2_ext;
        // Counter saturates at MAX_BEATS; the sticky flag records any beat past it.
        w_cnt_inc  = (r_cnt == MAXB) ? MAXB : r_cnt + BW'(1);
        w_ovf_next = r_ovf | (r_cnt == MAXB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            for (int i = 0; i < N; i++) r_prod[i] <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_sum  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
            r_sums    <= '0;
            r_beats   <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_last <= bus.in_valid & bus.in_last;
            if (bus.in_valid)
                for (int i = 0; i < N; i++) r_prod[i] <= w_prod[i];
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            if (r_s1_vld) r_s2_sum <= w_lsum;
            // With adv high a held result is being taken, so out_valid drops unless reloaded.
            if (r_s2_vld && r_s2_last) begin
                r_sums    <= w_acc_sum;
                r_beats   <= w_cnt_inc;
                r_out_ovf <= w_ovf_next;
                r_out_vld <= 1'b1;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf     <= 1'b0;
            end else begin
                r_out_vld <= 1'b0;
                if (r_s2_vld) begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_inc;
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.sums      = r_sums;
    assign bus.out_beats = r_beats;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_dot_product_stream.sv
// Bench for dot_product_stream: directed scenarios plus randomized vectors against an integer model.
module tb_dot_product_stream;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int OW = 2 * DW + $clog2(N) + $clog2(MB);
    localparam int BW = $clog2(MB) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dot_product_stream_if #(.N(N), .DW(DW), .MAX_BEATS(MB)) bus ();
    dot_product_stream_if #(.N(N), .DW(DW), .MAX_BEATS(MB)) bus_u ();

    dot_product_stream #(.N(N), .DW(DW), .MAX_BEATS(MB), .SIGNED(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    dot_product_stream #(.N(N), .DW(DW), .MAX_BEATS(MB), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset), .bus(bus_u));

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] obs_sums[$];
    logic [BW-1:0] obs_beats[$];
    logic          obs_ovf[$];
    logic [OW-1:0] exp_sums[$];
    logic [BW-1:0] exp_beats[$];
    logic          exp_ovf[$];
    longint        m_acc = 0;
    int            m_cnt = 0;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            obs_sums.push_back(bus.sums);
            obs_beats.push_back(bus.out_beats);
            obs_ovf.push_back(bus.out_ovf);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        obs_sums.delete(); obs_beats.delete(); obs_ovf.delete();
        exp_sums.delete(); exp_beats.delete(); exp_ovf.delete();
    endtask

    // Reference: plain integer dot product, modular wrap and saturating beat count.
    task automatic model_beat(input logic [DW-1:0] a0, a1, b0, b1, input logic last);
        logic [63:0] t;
        int x0, x1, y0, y1;
        x0 = int'($signed(a0)); x1 = int'($signed(a1));
        y0 = int'($signed(b0)); y1 = int'($signed(b1));
        m_acc = m_acc + longint'(x0 * y0 + x1 * y1);
        m_cnt++;
        if (last) begin
            t = 64'(m_acc);
            exp_sums.push_back(t[OW-1:0]);
            exp_beats.push_back(BW'(m_cnt > MB ? MB : m_cnt));
            exp_ovf.push_back(m_cnt > MB);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] a0, a1, b0, b1, input logic last);
        bit done;
        done = 1'b0;
        bus.inp1 = {a1, a0};
        bus.inp2 = {b1, b0};
        bus.in_last = last;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (done) model_beat(a0, a1, b0, b1, last);
        else begin
            checks++; errors++;
            $display("FAIL send_beat timeout: in_ready never rose");
        end
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 3000 && obs_sums.size() < n; t++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.sums !== '0) begin errors++; $display("FAIL rst_sums got %0d exp 0", bus.sums); end
        checks++; if (bus.out_beats !== '0) begin errors++; $display("FAIL rst_beats got %0d exp 0", bus.out_beats); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.out_ovf); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        clear_q();
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_e0 out_valid got %b exp 0", bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_e1 out_valid got %b exp 0", bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_e2 out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.sums !== OW'(11)) begin errors++; $display("FAIL single_sums got %0d exp 11", bus.sums); end
        checks++; if (bus.out_beats !== BW'(1) || bus.out_ovf !== 1'b0) begin
            errors++; $display("FAIL single_beats_ovf got %0d/%b exp 1/0", bus.out_beats, bus.out_ovf); end
        wait_results(1);
        checks++; if (obs_sums.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", obs_sums.size()); end
    endtask

    task automatic test_two_beat();
        clear_q();
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        send_beat(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_beat(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
        wait_results(2);
        checks++; if (obs_sums.size() != 2) begin errors++; $display("FAIL two_count got %0d exp 2", obs_sums.size()); end
        for (int i = 0; i < obs_sums.size() && i < 2; i++) begin
            checks++; if (obs_sums[i] !== OW'(94) || obs_beats[i] !== BW'(2)) begin
                errors++; $display("FAIL two_beat[%0d] got %0d/%0d exp 94/2", i, obs_sums[i], obs_beats[i]); end
        end
    endtask

    task automatic test_signed_extremes();
        clear_q();
        for (int b = 0; b < 16; b++) send_beat(8'h80, 8'h80, 8'h80, 8'h80, b == 15);
        wait_results(1);
        checks++; if (obs_sums.size() != 1) begin errors++; $display("FAIL ext_count got %0d exp 1", obs_sums.size()); end
        else begin
            checks++; if (obs_sums[0] !== OW'(524288) || obs_beats[0] !== BW'(16) || obs_ovf[0] !== 1'b0) begin
                errors++; $display("FAIL ext_result got %0d/%0d/%b exp 524288/16/0", obs_sums[0], obs_beats[0], obs_ovf[0]); end
        end
    endtask

    task automatic test_unsigned();
        bit found;
        found = 1'b0;
        bus_u.inp1 = 16'hFFFF;
        bus_u.inp2 = 16'hFFFF;
        bus_u.in_last = 1'b1;
        bus_u.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus_u.in_ready !== 1'b1) begin errors++; $display("FAIL uns_in_ready got %b exp 1", bus_u.in_ready); end
        @(posedge clk); #1;
        bus_u.in_valid = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (bus_u.out_valid) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!found) begin errors++; $display("FAIL uns_timeout got no out_valid exp 1"); end
        checks++; if (bus_u.sums !== OW'(130050) || bus_u.out_beats !== BW'(1) || bus_u.out_ovf !== 1'b0) begin
            errors++; $display("FAIL uns_result got %0d/%0d/%b exp 130050/1/0", bus_u.sums, bus_u.out_beats, bus_u.out_ovf); end
    endtask

    task automatic test_backpressure();
        clear_q();
        bus.out_ready = 1'b0;
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        send_beat(8'd3, 8'd4, 8'd3, 8'd4, 1'b1);
        send_beat(8'd5, 8'd6, 8'd3, 8'd4, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sums !== OW'(11)) begin
                errors++; $display("FAIL bp_hold[%0d] got rdy=%b vld=%b sums=%0d exp 0/1/11", c, bus.in_ready, bus.out_valid, bus.sums); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_results(3);
        checks++; if (obs_sums.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", obs_sums.size()); end
        else begin
            checks++; if (obs_sums[0] !== OW'(11) || obs_sums[1] !== OW'(25) || obs_sums[2] !== OW'(39)) begin
                errors++; $display("FAIL bp_order got %0d,%0d,%0d exp 11,25,39", obs_sums[0], obs_sums[1], obs_sums[2]); end
        end
    endtask

    task automatic test_overflow();
        clear_q();
        for (int b = 0; b < 17; b++) send_beat(8'd1, 8'd1, 8'd1, 8'd1, b == 16);
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        wait_results(2);
        checks++; if (obs_sums.size() != 2) begin errors++; $display("FAIL ovf_count got %0d exp 2", obs_sums.size()); end
        else begin
            checks++; if (obs_sums[0] !== OW'(34) || obs_beats[0] !== BW'(16) || obs_ovf[0] !== 1'b1) begin
                errors++; $display("FAIL ovf_result got %0d/%0d/%b exp 34/16/1", obs_sums[0], obs_beats[0], obs_ovf[0]); end
            checks++; if (obs_sums[1] !== OW'(11) || obs_beats[1] !== BW'(1) || obs_ovf[1] !== 1'b0) begin
                errors++; $display("FAIL ovf_next got %0d/%0d/%b exp 11/1/0", obs_sums[1], obs_beats[1], obs_ovf[1]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        for (int b = 0; b < 3; b++) send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.sums !== '0 || bus.out_beats !== '0 || bus.out_ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %b/%0d/%0d/%b exp 0/0/0/0", bus.out_valid, bus.sums, bus.out_beats, bus.out_ovf); end
        @(posedge clk); #1;
        reset = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
        send_beat(8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
        wait_results(1);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (obs_sums.size() != 1) begin errors++; $display("FAIL midrst_count got %0d exp 1", obs_sums.size()); end
        else begin
            checks++; if (obs_sums[0] !== OW'(8) || obs_beats[0] !== BW'(1)) begin
                errors++; $display("FAIL midrst_result got %0d/%0d exp 8/1", obs_sums[0], obs_beats[0]); end
        end
    endtask

    task automatic test_random();
        bit drv_done;
        int len;
        clear_q();
        drv_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 14; v++) begin
                    len = (v % 4 == 3) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++) begin
                        send_beat(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), b == len - 1);
                        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_results(exp_sums.size());
        checks++; if (obs_sums.size() != exp_sums.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", obs_sums.size(), exp_sums.size()); end
        for (int i = 0; i < obs_sums.size() && i < exp_sums.size(); i++) begin
            checks++; if (obs_sums[i] !== exp_sums[i] || obs_beats[i] !== exp_beats[i] || obs_ovf[i] !== exp_ovf[i]) begin
                errors++; $display("FAIL rand[%0d] got %0d/%0d/%b exp %0d/%0d/%b", i, obs_sums[i], obs_beats[i],
                                   obs_ovf[i], exp_sums[i], exp_beats[i], exp_ovf[i]); end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.inp1 = '0; bus.inp2 = '0; bus.out_ready = 1'b1;
        bus_u.in_valid = 1'b0; bus_u.in_last = 1'b0; bus_u.inp1 = '0; bus_u.inp2 = '0; bus_u.out_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_signed_extremes();
        test_unsigned();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
